fft_frame_streamer: RTL

Reads one or more frames of FFT input samples out of the preloaded synchronous sample ROM and presents them as a valid/ready stream to the burst FFT/IFFT core. It drives the ROM address and clock-enable, absorbs the ROM's one-cycle read latency, and tolerates arbitrary backpressure without losing or duplicating samples. It marks each frame's last word for the FFT framing logic.

---
 rtl/fft_stream_pkg.sv | 23 ++
 rtl/stream_skid_fifo.sv | 84 ++++++++
 rtl/fft_frame_streamer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the FFT frame streamer and its output FIFO.
package fft_stream_pkg;

    // Read-side sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Three entries cover the two-deep ROM pipeline plus one word parked
    // at the output, which is what keeps full throughput under tready=1.
    localparam int FIFO_DEPTH = 3;
    localparam int OCC_W      = 2;

    typedef logic [OCC_W-1:0] occ_t;

    // Circular pointer advance over FIFO_DEPTH entries.
    function automatic occ_t ptr_next(input occ_t p);
        return (p == occ_t'(FIFO_DEPTH - 1)) ? '0 : p + occ_t'(1);
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Three-entry register FIFO between the ROM read pipeline and the AXI-style
// output. The head entry drives the stream outputs directly from registers,
// so data stays stable while the consumer stalls.
module stream_skid_fifo
    import fft_stream_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output occ_t             occ_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    occ_t             rd_ptr_q;
    occ_t             wr_ptr_q;
    occ_t             occ_q;
    occ_t             occ_d;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop; a push into a full FIFO is only legal alongside a pop.
    always_comb begin
        do_pop  = pop_i && (occ_q != '0);
        do_push = push_i && ((occ_q != occ_t'(FIFO_DEPTH)) || do_pop);
        occ_d   = occ_q;
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage write at the write pointer; cleared on reset so outputs read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_ptr_q == occ_t'(i)) begin
                    mem_q[i] <= push_data_i;
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            occ_q <= occ_d;
        end
    end

    // Head-of-queue read mux.
    always_comb begin
        pop_data_o = mem_q[0];
        for (int i = 1; i < FIFO_DEPTH; i++) begin
            if (rd_ptr_q == occ_t'(i)) begin
                pop_data_o = mem_q[i];
            end
        end
    end

    assign occ_o   = occ_q;
    assign empty_o = (occ_q == '0);

endmodule

// File: rtl/fft_frame_streamer.sv
// Streams frames of samples from a synchronous ROM into a valid/ready
// interface. The read side issues ROM reads only while the FIFO plus the
// one in-flight read has room, so backpressure never loses a sample and
// the issue decision never depends on m_tready.
module fft_frame_streamer
    import fft_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  loop,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_clk_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  busy_q;
    logic                  inflight_q;
    logic                  run_end_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] idx_d;
    logic                  done_q;
    logic                  frame_done_q;

    logic                  issue;
    logic                  last_read;
    logic                  handshake;
    logic                  tlast_w;
    logic [DATA_WIDTH:0]   head;
    logic                  head_end;
    occ_t                  occ;
    logic                  empty;

    // The FIFO carries one extra bit alongside each sample: set only on the
    // final word of a run (last read issued with loop low), so the drain
    // logic knows which tlast ends the run versus an intermediate frame.
    stream_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i({run_end_q, mem_rd_data}),
        .pop_i      (handshake),
        .pop_data_o (head),
        .occ_o      (occ),
        .empty_o    (empty)
    );

    // Issue and handshake decode; issue looks only at registered state.
    always_comb begin
        issue     = (state_q == RUN) &&
                    (({1'b0, occ} + {2'b0, inflight_q}) < 3'(FIFO_DEPTH));
        last_read = (mem_addr_q == LAST_IDX);
        head_end  = head[DATA_WIDTH];
        handshake = !empty && m_tready;
        tlast_w   = !empty && (idx_q == LAST_IDX);
        idx_d     = idx_q;
        if (handshake) begin
            idx_d = tlast_w ? '0 : idx_q + ADDR_WIDTH'(1);
        end
    end

    // Sequencer: launch, address generation with frame wrap, and drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        mem_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        mem_addr_q <= last_read ? '0 : mem_addr_q + ADDR_WIDTH'(1);
                        if (last_read && !loop) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The end-tagged word is the last one pushed, so when it
                    // hands off nothing is in flight and the FIFO empties.
                    if (handshake && head_end && !inflight_q && (occ == occ_t'(1))) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ROM pipeline tracking, output word index and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            run_end_q    <= 1'b0;
            idx_q        <= '0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            inflight_q   <= issue;
            run_end_q    <= issue && last_read && !loop;
            idx_q        <= idx_d;
            done_q       <= handshake && head_end;
            frame_done_q <= handshake && tlast_w;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_done = frame_done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_clk_en = issue;
    assign m_tdata    = head[DATA_WIDTH-1:0];
    assign m_tvalid   = !empty;
    assign m_tlast    = tlast_w;

endmodule
